// File: rtl/eth_manchester_tx_if.sv
// eth_manchester_tx_if: byte-stream source handshake for the Manchester transmitter
interface eth_manchester_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  modport master(output tx_start, tx_data, tx_valid, tx_last, input tx_ready);
  modport slave(input tx_start, tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/eth_manchester_tx.sv
// eth_manchester_tx: byte stream to 10BASE-T Manchester line with preamble, SFD, ETD and inter-frame gap
module eth_manchester_tx #(
  parameter int         PREAMBLE_BYTES = 7,
  parameter logic [7:0] SFD_BYTE       = 8'hD5,
  parameter int         ETD_CLKS       = 4,
  parameter int         IFG_BITS       = 96
) (
  input  logic               w_clk,
  input  logic               n_rst,
  eth_manchester_tx_if.slave bus,
  output logic               Ethernet_Out,
  output logic               tx_en,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_error
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] SFD  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] ETD  = 3'd4;
  localparam logic [2:0] IFG  = 3'd5;
  localparam logic [7:0] PRE_END = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0] ETD_END = 8'(ETD_CLKS - 1);
  localparam logic [7:0] IFG_END = 8'(2 * IFG_BITS - 1);
  logic [2:0] state, bit_cnt;
  logic [7:0] cnt, sh, hold;
  logic       half, cur_last, full, hold_last, last_acc, ser, hs, byte_end;
  always_comb begin
    ser          = state == PRE || state == SFD || state == DATA;
    byte_end     = ser && half && bit_cnt == 3'd7;
    bus.tx_ready = ser && !full && !last_acc;
    hs           = bus.tx_valid && bus.tx_ready;
    Ethernet_Out = ser ? (half ? sh[0] : ~sh[0]) : state == ETD;
    tx_en        = ser || state == ETD;
    tx_busy      = state != IDLE;
    tx_done      = state == IFG && cnt == 8'd0;
  end
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      cnt       <= 8'd0;
      sh        <= 8'd0;
      hold      <= 8'd0;
      half      <= 1'b0;
      cur_last  <= 1'b0;
      full      <= 1'b0;
      hold_last <= 1'b0;
      last_acc  <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.tx_start) begin
          state    <= PRE;
          sh       <= 8'h55;
          half     <= 1'b0;
          bit_cnt  <= 3'd0;
          cnt      <= 8'd0;
          cur_last <= 1'b0;
          full     <= 1'b0;
          last_acc <= 1'b0;
          tx_error <= 1'b0;
        end
        PRE, SFD, DATA: begin
          half <= ~half;
          if (half) begin
            bit_cnt <= bit_cnt + 3'd1;
            sh      <= {1'b0, sh[7:1]};
          end
          if (byte_end) begin
            if (state == PRE) begin
              cnt   <= cnt + 8'd1;
              sh    <= cnt == PRE_END ? SFD_BYTE : 8'h55;
              state <= cnt == PRE_END ? SFD : PRE;
            end else if (state == DATA && cur_last) begin
              state <= ETD;
              cnt   <= 8'd0;
            end else if (full) begin
              sh       <= hold;
              cur_last <= hold_last;
              full     <= 1'b0;
              state    <= DATA;
            end else begin
              tx_error <= 1'b1;
              state    <= ETD;
              cnt      <= 8'd0;
            end
          end
        end
        ETD: begin
          cnt   <= cnt == ETD_END ? 8'd0 : cnt + 8'd1;
          state <= cnt == ETD_END ? IFG : ETD;
        end
        IFG: begin
          cnt   <= cnt + 8'd1;
          state <= cnt == IFG_END ? IDLE : IFG;
        end
        default: state <= IDLE;
      endcase
      if (hs) begin
        hold      <= bus.tx_data;
        hold_last <= bus.tx_last;
        full      <= 1'b1;
        last_acc  <= last_acc | bus.tx_last;
      end
    end
  end
endmodule

// File: doc/eth_manchester_tx.md
Name: eth_manchester_tx

Overview:
Byte-stream to 10BASE-T Manchester transmitter. It is the Ethernet-egress counterpart of the Ethernet-ingress path in the shabang top level. It accepts frame bytes (destination MAC through FCS, already formed) over a valid/ready handshake with a one-byte holding register. It prepends preamble and SFD, Manchester-encodes LSB-first on a single serial line, appends an end-of-frame marker, and enforces the inter-frame gap.

Parameters:
PREAMBLE_BYTES, 7, number of 0x55 preamble bytes before SFD
SFD_BYTE, 8'hD5, start-of-frame delimiter value
ETD_CLKS, 4, clocks the line is held high after the last data bit (end-of-transmission delimiter)
IFG_BITS, 96, inter-frame gap in bit times (2 clocks per bit)

Ports:
w_clk  in  1  Ethernet clock, 20 MHz (2x the 10 Mb/s bit rate)
n_rst  in  1  asynchronous active-low reset
tx_start  in  1  request to begin a frame; sampled only in IDLE
tx_data  in  8  frame byte
tx_valid  in  1  tx_data/tx_last valid
tx_last  in  1  qualifies tx_data as the final frame byte
tx_ready  out  1  holding register can accept a byte
Ethernet_Out  out  1  Manchester serial line
tx_en  out  1  high from the first preamble half-bit through the end of ETD
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse on the first IFG cycle after a frame ends
tx_error  out  1  sticky underrun flag; cleared by the next accepted tx_start

Behaviour:
- Reset values: Ethernet_Out=0, tx_en=0, tx_busy=0, tx_done=0, tx_error=0, tx_ready=0. Holding register is empty and the FSM is in IDLE.
- Encoding: each bit spans 2 clocks. First half = ~b, second half = b, so 0 is high-to-low and 1 is low-to-high. Bytes go out LSB first.
- FSM states: IDLE -> PREAMBLE -> SFD -> DATA -> ETD -> IFG -> IDLE.
- IDLE:
  - Ethernet_Out=0.
  - If tx_start=1, the next cycle enters PREAMBLE, clears tx_error, and drives the first half-bit.
- PREAMBLE: PREAMBLE_BYTES x 16 clocks of 0x55, which is the serial pattern 1,0,1,0...
- SFD: 16 clocks of SFD_BYTE.
- Byte boundary at the end of SFD or of any DATA byte (the cycle after the 2nd half of bit 7):
  - If the current byte was last, go to ETD.
  - Else if the holding register is full, move it into the shift register, mark the register empty, and stay in or enter DATA.
  - Else (underrun) set tx_error=1 and go to ETD without sending further bits.
- DATA: shifts one bit every 2 clocks. A 3-bit bit counter and a 1-bit half counter govern shifting.
- tx_ready:
  - Asserted while in PREAMBLE, SFD or DATA, the holding register is empty, and no last byte has yet been accepted.
  - A handshake completes when tx_valid && tx_ready at a rising edge; the register captures tx_data and tx_last.
  - If the register is emptied and refilled in the same cycle, the load wins and the register stays full.
  - tx_ready may be low while tx_valid is high. The source holds data stable until accepted.
- ETD: Ethernet_Out=1 for ETD_CLKS clocks, tx_en=1. It then enters IFG with Ethernet_Out=0 and tx_en=0.
- IFG:
  - Lasts IFG_BITS x 2 clocks (8-bit counter).
  - tx_done pulses on the first IFG cycle.
  - tx_start is ignored (not queued).
  - Returns to IDLE afterwards.
- tx_en=1 exactly in PREAMBLE, SFD, DATA and ETD.
- Frame timing with N accepted bytes and no underrun:
  - The first Ethernet_Out half-bit is the cycle after tx_start.
  - Active length = 16*PREAMBLE_BYTES + 16 + 16N + ETD_CLKS clocks (N=1 gives 148).
- tx_start is ignored outside IDLE. Bytes offered in IDLE or IFG are not accepted.
- Asynchronous reset mid-frame immediately returns all outputs to their reset values and discards any held byte. No ETD is sent.

Test Plan:
1. Reset with n_rst=0 during DATA -> Ethernet_Out, tx_en, tx_busy and tx_ready go 0 immediately; IDLE after release.
2. tx_start plus one byte 0xA5 with last=1 offered at once -> 56 preamble bits 1,0,1,0...; then SFD bits 1,0,1,0,1,0,1,1; then data bits 1,0,1,0,0,1,0,1 Manchester-coded. Then 4 clocks high, tx_done pulse at clock 148 after start, tx_busy low 192 clocks later.
3. 3-byte frame 0x01,0x02,0x03 with tx_valid delayed 50 clocks on byte 2 but before its boundary -> no error; 16*3 data clocks, tx_error=0.
4. Underrun: second byte never offered -> after byte 1 bit 7, ETD begins immediately, tx_error=1, tx_done pulses; tx_error clears on the next tx_start.
5. tx_start pulsed during IFG -> ignored, no frame; a tx_start after tx_busy falls starts a frame the next cycle.
6. tx_valid held high continuously with a 2-byte frame -> exactly 2 handshakes; tx_ready stays 0 after last is accepted.
